// File: rtl/display_pkg.sv
// Shared types and elaboration helpers for the multiplexed display scanner.
package display_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Select / counter width, never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 1) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned div_of(input int unsigned clk_hz, input int unsigned refresh_hz);
    return clk_hz / refresh_hz;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/REFRESH_HZ clocks.
module scan_prescaler
  import display_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned REFRESH_HZ = 400
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = div_of(CLK_HZ, REFRESH_HZ);
  localparam int unsigned CW  = sel_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed-display scanner: masked digit stepping, anti-ghost blanking, active-low anodes.
// Optional brightness PWM when SCAN_DIMMING_EN is defined.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned REFRESH_HZ   = 400,
  parameter int unsigned BLANK_CYCLES = 1000,
  localparam int unsigned SEL_W       = sel_width(NUM_DIGITS)
) (
  input  logic                  clk_100MHz,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] digit_en,
`ifdef SCAN_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [SEL_W-1:0]      select,
  output logic [NUM_DIGITS-1:0] anode_n,
  output logic                  frame_start
);

  localparam int unsigned DIV = div_of(CLK_HZ, REFRESH_HZ);
  localparam int unsigned BW  = sel_width(BLANK_CYCLES + 1);
  localparam int unsigned CW  = SEL_W + 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  if (DIV < 2 || BLANK_CYCLES >= DIV) begin : g_bad_cfg
    $error("display_scan_ctrl: need DIV >= 2 and BLANK_CYCLES < DIV");
  end

  scan_state_t           r_state, w_state_d;
  logic [BW-1:0]         r_blank_cnt, w_blank_cnt_d;
  logic [SEL_W-1:0]      r_select, w_select_d, w_next_sel;
  logic [NUM_DIGITS-1:0] r_anode_n, w_anode_n_d;
  logic                  r_frame_start, w_frame_start_d;
  logic                  w_tick, w_found, w_blank_done, w_pwm_on;

  scan_prescaler #(
    .CLK_HZ     (CLK_HZ),
    .REFRESH_HZ (REFRESH_HZ)
  ) u_prescaler (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .tick       (w_tick)
  );

`ifdef SCAN_DIMMING_EN
  logic [3:0] r_pwm_cnt, w_pwm_next;
  assign w_pwm_next = r_pwm_cnt + 4'd1;
  // Compare against the count the anode register will be paired with.
  assign w_pwm_on   = (w_pwm_next <= brightness);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= w_pwm_next;
  end
`else
  assign w_pwm_on = 1'b1;
`endif

  // Upward search from select+1; wrapping back onto select itself keeps a lone digit in place.
  always_comb begin
    logic [CW-1:0] cand;
    cand       = '0;
    w_found    = 1'b0;
    w_next_sel = r_select;
    for (int i = 1; i <= int'(NUM_DIGITS); i++) begin
      cand = {1'b0, r_select} + CW'(i);
      if (cand >= CW'(NUM_DIGITS)) cand = cand - CW'(NUM_DIGITS);
      if (!w_found && digit_en[cand[SEL_W-1:0]]) begin
        w_found    = 1'b1;
        w_next_sel = cand[SEL_W-1:0];
      end
    end
  end

  assign w_blank_done = (BLANK_CYCLES == 0) || (r_blank_cnt == BLANK_LAST);

  always_comb begin
    w_state_d       = r_state;
    w_blank_cnt_d   = r_blank_cnt;
    w_select_d      = r_select;
    w_frame_start_d = 1'b0;
    if (w_tick) begin
      w_select_d      = w_next_sel;
      w_state_d       = BLANK;
      w_blank_cnt_d   = '0;
      w_frame_start_d = w_found && (w_next_sel <= r_select);
    end else if (r_state == BLANK) begin
      if (w_blank_done) w_state_d = SHOW;
      else              w_blank_cnt_d = r_blank_cnt + 1'b1;
    end

    w_anode_n_d = '1;
    if (w_state_d == SHOW && digit_en[w_select_d] && w_pwm_on) begin
      w_anode_n_d[w_select_d] = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BLANK;
      r_blank_cnt   <= '0;
      r_select      <= '0;
      r_anode_n     <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_blank_cnt   <= w_blank_cnt_d;
      r_select      <= w_select_d;
      r_anode_n     <= w_anode_n_d;
      r_frame_start <= w_frame_start_d;
    end
  end

  assign select      = r_select;
  assign anode_n     = r_anode_n;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl against a slot/phase reference model.
module tb_display_scan_ctrl;

  localparam int unsigned ND      = 8;
  localparam int unsigned DIV     = 10;
  localparam int unsigned BLANK_C = 2;

  logic       clk_100MHz = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] digit_en   = 8'hFF;
  logic [2:0] select;
  logic [7:0] anode_n;
  logic       frame_start;
`ifdef SCAN_DIMMING_EN
  logic [3:0] brightness = 4'd15;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: cycles since reset release, current digit, frame pulse, last sampled inputs.
  int unsigned n;
  int unsigned m_sel;
  logic        m_frame;
  logic [7:0]  m_en;
  logic [3:0]  m_br;

  display_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .CLK_HZ       (1000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (BLANK_C)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst_n       (rst_n),
    .digit_en    (digit_en),
`ifdef SCAN_DIMMING_EN
    .brightness  (brightness),
`endif
    .select      (select),
    .anode_n     (anode_n),
    .frame_start (frame_start)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  function automatic int unsigned next_enabled(input int unsigned sel, input logic [7:0] en);
    for (int unsigned k = 1; k <= ND; k++) begin
      int unsigned idx;
      idx = (sel + k) % ND;
      if (en[idx]) return idx;
    end
    return sel;
  endfunction

  // Every slot is DIV cycles; the first BLANK_C of them are dark.
  function automatic logic [7:0] exp_anode();
    logic [7:0] a;
    a = 8'hFF;
    if ((n % DIV) >= BLANK_C && m_en[m_sel]) a[m_sel] = 1'b0;
`ifdef SCAN_DIMMING_EN
    if ((n % 16) > m_br) a = 8'hFF;
`endif
    return a;
  endfunction

  task automatic reset_model();
    n = 0; m_sel = 0; m_frame = 1'b0; m_en = 8'hFF; m_br = 4'd15;
  endtask

  task automatic step();
    logic [7:0]  en_s;
    int unsigned nx;
    en_s = digit_en;
`ifdef SCAN_DIMMING_EN
    m_br = brightness;
`endif
    @(posedge clk_100MHz);
    n++;
    m_frame = 1'b0;
    if (n % DIV == 0) begin
      nx      = next_enabled(m_sel, en_s);
      m_frame = (en_s != 0) && (nx <= m_sel);
      m_sel   = nx;
    end
    m_en = en_s;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; digit_en = 8'hFF;
    repeat (3) @(posedge clk_100MHz);
    #1;
    n_cmp++; if (anode_n !== 8'hFF) begin n_bad++; $display("FAIL reset_anode got=%h exp=ff", anode_n); end
    n_cmp++; if (select !== 3'd0) begin n_bad++; $display("FAIL reset_select got=%0d exp=0", select); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame got=%b exp=0", frame_start); end
    @(negedge clk_100MHz); rst_n = 1'b1; reset_model();
    for (int c = 0; c < 13; c++) begin
      step();
      n_cmp++;
      if ({select, anode_n, frame_start} !== {3'(m_sel), exp_anode(), m_frame}) begin
        n_bad++;
        $display("FAIL reset_scan n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                 n, select, anode_n, frame_start, m_sel, exp_anode(), m_frame);
      end
      if (n == 9) begin n_cmp++; if (select !== 3'd0) begin n_bad++; $display("FAIL pre_tick_select got=%0d exp=0", select); end end
      if (n == 10) begin n_cmp++; if (select !== 3'd1) begin n_bad++; $display("FAIL first_tick_select got=%0d exp=1", select); end end
      if (n == 12) begin n_cmp++; if (anode_n !== 8'hFD) begin n_bad++; $display("FAIL first_show_anode got=%h exp=fd", anode_n); end end
    end
  endtask

  task automatic test_full_scan();
    int ff_cnt = 0, seen_fs = 0, exp_fs = 0;
    bit in_slot = 0;
    digit_en = 8'hFF;
    for (int c = 0; c < 9 * DIV; c++) begin
      step();
      n_cmp++;
      if ({select, anode_n, frame_start} !== {3'(m_sel), exp_anode(), m_frame}) begin
        n_bad++;
        $display("FAIL full_scan n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                 n, select, anode_n, frame_start, m_sel, exp_anode(), m_frame);
      end
      if (n % DIV == 0) begin in_slot = 1; ff_cnt = 0; end
      if (anode_n == 8'hFF) ff_cnt++;
      if (in_slot && (n % DIV == DIV - 1)) begin
        n_cmp++;
        if (ff_cnt != BLANK_C) begin n_bad++; $display("FAIL blank_len n=%0d got=%0d exp=%0d", n, ff_cnt, BLANK_C); end
      end
      seen_fs += int'(frame_start);
      exp_fs  += int'(m_frame);
    end
    n_cmp++;
    if (seen_fs != exp_fs || seen_fs != 1) begin
      n_bad++; $display("FAIL full_scan_frames got=%0d exp=%0d", seen_fs, exp_fs);
    end
  endtask

  task automatic test_two_digits();
    bit started = 0;
    digit_en = 8'b0000_0101;
    for (int c = 0; c < 5 * DIV; c++) begin
      step();
      n_cmp++;
      if ({select, anode_n, frame_start} !== {3'(m_sel), exp_anode(), m_frame}) begin
        n_bad++;
        $display("FAIL two_digits n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                 n, select, anode_n, frame_start, m_sel, exp_anode(), m_frame);
      end
      if (n % DIV == 0) started = 1;
      if (started && (n % DIV) >= BLANK_C) begin
        n_cmp++;
        if (anode_n !== 8'hFB && anode_n !== 8'hFE) begin
          n_bad++; $display("FAIL two_digits_show n=%0d got=%h exp=fb/fe", n, anode_n);
        end
      end
    end
  endtask

  task automatic test_disable_mid_show();
    logic [2:0] frozen;
    digit_en = 8'hFF;
    while (n % DIV != 5) step();
    digit_en = 8'h00;
    frozen   = select;
    step();
    n_cmp++; if (anode_n !== 8'hFF) begin n_bad++; $display("FAIL disable_anode got=%h exp=ff", anode_n); end
    for (int c = 0; c < 5 * DIV; c++) begin
      step();
      n_cmp++;
      if ({select, anode_n, frame_start} !== {frozen, 8'hFF, 1'b0}) begin
        n_bad++;
        $display("FAIL disabled_hold n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=ff fs=0",
                 n, select, anode_n, frame_start, frozen);
      end
    end
  endtask

  task automatic test_async_reset();
    digit_en = 8'hFF;
    for (int c = 0; c < 3; c++) step();
    while (n % DIV != 5) step();
    #2; rst_n = 1'b0; #1;
    n_cmp++; if (anode_n !== 8'hFF) begin n_bad++; $display("FAIL async_anode got=%h exp=ff", anode_n); end
    n_cmp++; if (select !== 3'd0) begin n_bad++; $display("FAIL async_select got=%0d exp=0", select); end
    @(posedge clk_100MHz);
    @(negedge clk_100MHz); rst_n = 1'b1; reset_model();
    for (int c = 0; c < DIV + 3; c++) begin
      step();
      n_cmp++;
      if ({select, anode_n, frame_start} !== {3'(m_sel), exp_anode(), m_frame}) begin
        n_bad++;
        $display("FAIL after_reset n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                 n, select, anode_n, frame_start, m_sel, exp_anode(), m_frame);
      end
      if (n == DIV - 1) begin n_cmp++; if (select !== 3'd0) begin n_bad++; $display("FAIL early_tick got=%0d exp=0", select); end end
      if (n == DIV) begin n_cmp++; if (select !== 3'd1) begin n_bad++; $display("FAIL tick_after_reset got=%0d exp=1", select); end end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int unsigned len;
      digit_en = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
`ifdef SCAN_DIMMING_EN
      brightness = 4'($urandom);
`endif
      len = $urandom_range(6, 35);
      for (int unsigned c = 0; c < len; c++) begin
        step();
        n_cmp++;
        if ({select, anode_n, frame_start} !== {3'(m_sel), exp_anode(), m_frame}) begin
          n_bad++;
          $display("FAIL random en=%h n=%0d got sel=%0d an=%h fs=%b exp sel=%0d an=%h fs=%b",
                   m_en, n, select, anode_n, frame_start, m_sel, exp_anode(), m_frame);
        end
      end
    end
  endtask

`ifdef SCAN_DIMMING_EN
  task automatic test_dimming();
    int lit = 0, exp_lit = 0;
    digit_en = 8'hFF; brightness = 4'd3;
    for (int c = 0; c < 16 * DIV; c++) begin
      step();
      if ((n % DIV) >= BLANK_C) begin
        lit     += int'(anode_n != 8'hFF);
        exp_lit += int'((n % 16) <= 3);
      end
    end
    n_cmp++; if (lit != exp_lit) begin n_bad++; $display("FAIL dim_b3 got=%0d exp=%0d", lit, exp_lit); end
    brightness = 4'd15;
    step();
    for (int c = 0; c < 3 * DIV; c++) begin
      step();
      if ((n % DIV) >= BLANK_C) begin
        n_cmp++;
        if (anode_n == 8'hFF) begin n_bad++; $display("FAIL dim_b15 n=%0d got=%h exp=lit", n, anode_n); end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_two_digits();
    test_disable_mid_show();
    test_async_reset();
    test_random();
`ifdef SCAN_DIMMING_EN
    test_dimming();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
